// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR flag bank arbiter: command encodings and FSM states.
package sr_bank_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_HOLD = 2'b00;
    localparam cmd_t CMD_SET  = 2'b01;
    localparam cmd_t CMD_RST  = 2'b10;
    localparam cmd_t CMD_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        APPLY = 2'd2
    } state_t;

endpackage

// File: rtl/sr_bank_arbiter_if.sv
// Request/grant and flag-bank signal bundle between requesters and the bank arbiter.
interface sr_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int AW    = $clog2(NBITS)
);
    localparam int EW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  cmd;
    logic [AW*NREQ-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NBITS-1:0]   s_vec;
    logic [NBITS-1:0]   r_vec;
    logic [NBITS-1:0]   q;
    logic [NBITS-1:0]   qbar;
    logic               err;
    logic [EW-1:0]      err_src;
    logic               busy;

    modport master (
        output req, cmd, addr,
        input  gnt, s_vec, r_vec, q, qbar, err, err_src, busy
    );

    modport slave (
        input  req, cmd, addr,
        output gnt, s_vec, r_vec, q, qbar, err, err_src, busy
    );

endinterface

// File: rtl/sr_bank_arbiter_cell.sv
// One clocked SR flag; simultaneous set and reset leave the flag unchanged.
module sr_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (s && !r) begin
            r_q <= 1'b1;
        end else if (r && !s) begin
            r_q <= 1'b0;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that serialises set/reset commands from NREQ requesters
// into a bank of SR flags, one command every three cycles.
module sr_bank_arbiter
    import sr_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int AW    = $clog2(NBITS)
) (
    input  logic              clk,
    input  logic              rst,
    sr_bank_arbiter_if.slave  bank
);

    localparam int PW = $clog2(NREQ);

    state_t r_state;
    state_t w_state_next;

    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win;
    cmd_t             r_cmd;
    logic [AW-1:0]    r_addr;
    logic [NREQ-1:0]  r_gnt;
    logic [NBITS-1:0] r_s_vec;
    logic [NBITS-1:0] r_r_vec;
    logic             r_err;
    logic [PW-1:0]    r_err_src;

    logic             w_any;
    logic [PW-1:0]    w_win;
    logic             w_addr_ok;
    logic [PW-1:0]    w_ptr_next;
    cmd_t             w_cmd_arr  [NREQ];
    logic [AW-1:0]    w_addr_arr [NREQ];
    logic [NBITS-1:0] w_q;
    logic [NBITS-1:0] w_qbar;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_cmd_arr[gi]  = bank.cmd[2*gi +: 2];
            assign w_addr_arr[gi] = bank.addr[AW*gi +: AW];
        end
    endgenerate

    // First asserted request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && bank.req[(int'(r_ptr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_win = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Only reachable when NBITS is not a power of two; such commands act as hold.
    assign w_addr_ok  = ({1'b0, r_addr} < (AW+1)'(NBITS));
    assign w_ptr_next = (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = GRANT;
            GRANT:   w_state_next = APPLY;
            APPLY:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_win     <= '0;
            r_cmd     <= CMD_HOLD;
            r_addr    <= '0;
            r_gnt     <= '0;
            r_s_vec   <= '0;
            r_r_vec   <= '0;
            r_err     <= 1'b0;
            r_err_src <= '0;
        end else begin
            r_gnt   <= '0;
            r_s_vec <= '0;
            r_r_vec <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win  <= w_win;
                        r_cmd  <= w_cmd_arr[w_win];
                        r_addr <= w_addr_arr[w_win];
                        r_gnt  <= NREQ'(1) << w_win;
                    end
                end
                GRANT: begin
                    r_ptr <= w_ptr_next;
                    if (w_addr_ok) begin
                        case (r_cmd)
                            CMD_SET: r_s_vec <= NBITS'(1) << r_addr;
                            CMD_RST: r_r_vec <= NBITS'(1) << r_addr;
                            CMD_ILL: begin
                                r_err <= 1'b1;
                                if (!r_err) r_err_src <= r_win;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_cell
            sr_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .s    (r_s_vec[gi]),
                .r    (r_r_vec[gi]),
                .q    (w_q[gi]),
                .qbar (w_qbar[gi])
            );
        end
    endgenerate

    assign bank.gnt     = r_gnt;
    assign bank.s_vec   = r_s_vec;
    assign bank.r_vec   = r_r_vec;
    assign bank.q       = w_q;
    assign bank.qbar    = w_qbar;
    assign bank.err     = r_err;
    assign bank.err_src = r_err_src;
    assign bank.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Self-checking bench for sr_bank_arbiter: directed scenarios plus randomized
// traffic against a transaction-level round-robin/flag model.
module tb_sr_bank_arbiter;
    import sr_bank_pkg::*;

    localparam int NREQ  = 4;
    localparam int NBITS = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_bank_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW)) bif ();

    sr_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bank (bif)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] c_gnt, c_gnt_apply;
    logic [7:0] c_s, c_r, c_q, c_qbar;
    logic       c_busy_g, c_busy_end, c_err;
    logic [1:0] c_err_src;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] c, input int a);
        logic [2:0] a3;
        a3 = a[2:0];
        bif.req[i]         = 1'b1;
        bif.cmd[2*i +: 2]  = c;
        bif.addr[3*i +: 3] = a3;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bif.req  = '0;
        bif.cmd  = '0;
        bif.addr = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Walks one command through GRANT, APPLY and back to IDLE, recording outputs.
    task automatic capture_txn();
        step();
        c_gnt    = bif.gnt;
        c_busy_g = bif.busy;
        bif.req  = bif.req & ~c_gnt;
        step();
        c_s         = bif.s_vec;
        c_r         = bif.r_vec;
        c_gnt_apply = bif.gnt;
        c_err       = bif.err;
        c_err_src   = bif.err_src;
        step();
        c_q        = bif.q;
        c_qbar     = bif.qbar;
        c_busy_end = bif.busy;
    endtask

    function automatic int pick(input logic [3:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst     = 1'b1;
        bif.req = 4'b1111;
        bif.cmd = 8'h55;
        step();
        step();
        checks++; if (bif.gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bif.gnt); end
        checks++; if (bif.s_vec !== 8'h00 || bif.r_vec !== 8'h00) begin failures++; $display("FAIL reset_vec s=%h r=%h exp=00", bif.s_vec, bif.r_vec); end
        checks++; if (bif.q !== 8'h00 || bif.qbar !== 8'hFF) begin failures++; $display("FAIL reset_q q=%h qbar=%h exp=00/ff", bif.q, bif.qbar); end
        checks++; if (bif.err !== 1'b0 || bif.err_src !== 2'd0) begin failures++; $display("FAIL reset_err err=%b src=%0d exp=0/0", bif.err, bif.err_src); end
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
        rst     = 1'b0;
        bif.req = '0;
        bif.cmd = '0;
        $display("test_reset done");
    endtask

    task automatic test_single_set();
        do_reset();
        set_req(0, CMD_SET, 3);
        capture_txn();
        checks++; if (c_gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", c_gnt); end
        checks++; if (c_busy_g !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", c_busy_g); end
        checks++; if (c_gnt_apply !== 4'b0) begin failures++; $display("FAIL single_gnt_once got=%b exp=0000", c_gnt_apply); end
        checks++; if (c_s !== 8'h08 || c_r !== 8'h00) begin failures++; $display("FAIL single_pulse s=%h r=%h exp=08/00", c_s, c_r); end
        checks++; if (c_q !== 8'h08 || c_qbar !== 8'hF7) begin failures++; $display("FAIL single_q q=%h qbar=%h exp=08/f7", c_q, c_qbar); end
        checks++; if (bif.s_vec !== 8'h00 || c_busy_end !== 1'b0) begin failures++; $display("FAIL single_after s=%h busy=%b exp=00/0", bif.s_vec, c_busy_end); end
        $display("test_single_set q=%h", c_q);
    endtask

    task automatic test_all_set();
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, CMD_SET, i);
        for (int n = 0; n < NREQ; n++) begin
            capture_txn();
            eg = 4'b0001 << n;
            checks++; if (c_gnt !== eg) begin failures++; $display("FAIL all_gnt%0d got=%b exp=%b", n, c_gnt, eg); end
            $display("test_all_set grant %0d gnt=%b q=%h", n, c_gnt, c_q);
        end
        checks++; if (c_q !== 8'h0F) begin failures++; $display("FAIL all_q got=%h exp=0f", c_q); end
    endtask

    task automatic test_illegal();
        do_reset();
        set_req(2, CMD_ILL, 5);
        capture_txn();
        checks++; if (c_gnt !== 4'b0100) begin failures++; $display("FAIL ill_gnt got=%b exp=0100", c_gnt); end
        checks++; if (c_s !== 8'h00 || c_r !== 8'h00) begin failures++; $display("FAIL ill_pulse s=%h r=%h exp=00/00", c_s, c_r); end
        checks++; if (c_q !== 8'h00) begin failures++; $display("FAIL ill_q got=%h exp=00", c_q); end
        checks++; if (c_err !== 1'b1 || c_err_src !== 2'd2) begin failures++; $display("FAIL ill_err err=%b src=%0d exp=1/2", c_err, c_err_src); end
        set_req(1, CMD_ILL, 0);
        capture_txn();
        checks++; if (c_gnt !== 4'b0010) begin failures++; $display("FAIL ill2_gnt got=%b exp=0010", c_gnt); end
        checks++; if (c_err !== 1'b1 || c_err_src !== 2'd2) begin failures++; $display("FAIL ill2_err err=%b src=%0d exp=1/2", c_err, c_err_src); end
        $display("test_illegal err=%b err_src=%0d", c_err, c_err_src);
    endtask

    task automatic test_same_addr();
        do_reset();
        set_req(3, CMD_SET, 3);
        capture_txn();
        checks++; if (c_q !== 8'h08) begin failures++; $display("FAIL same_pre_q got=%h exp=08", c_q); end
        set_req(0, CMD_RST, 3);
        set_req(1, CMD_SET, 3);
        capture_txn();
        checks++; if (c_gnt !== 4'b0001 || c_r !== 8'h08 || c_q !== 8'h00) begin failures++; $display("FAIL same_first gnt=%b r=%h q=%h exp=0001/08/00", c_gnt, c_r, c_q); end
        capture_txn();
        checks++; if (c_gnt !== 4'b0010 || c_s !== 8'h08 || c_q !== 8'h08) begin failures++; $display("FAIL same_second gnt=%b s=%h q=%h exp=0010/08/08", c_gnt, c_s, c_q); end
        $display("test_same_addr q=%h", c_q);
    endtask

    task automatic test_reset_in_apply();
        do_reset();
        set_req(2, CMD_SET, 6);
        step();
        checks++; if (bif.gnt !== 4'b0100) begin failures++; $display("FAIL rsta_gnt got=%b exp=0100", bif.gnt); end
        bif.req = '0;
        step();
        checks++; if (bif.s_vec !== 8'h40) begin failures++; $display("FAIL rsta_pulse got=%h exp=40", bif.s_vec); end
        rst = 1'b1;
        step();
        checks++; if (bif.q !== 8'h00 || bif.s_vec !== 8'h00 || bif.busy !== 1'b0) begin failures++; $display("FAIL rsta_state q=%h s=%h busy=%b exp=00/00/0", bif.q, bif.s_vec, bif.busy); end
        rst = 1'b0;
        set_req(1, CMD_SET, 1);
        set_req(3, CMD_SET, 2);
        capture_txn();
        checks++; if (c_gnt !== 4'b0010 || c_q !== 8'h02) begin failures++; $display("FAIL rsta_next gnt=%b q=%h exp=0010/02", c_gnt, c_q); end
        capture_txn();
        $display("test_reset_in_apply q=%h", c_q);
    endtask

    task automatic test_random();
        logic [3:0] pend;
        logic [1:0] pc [NREQ];
        int         pa [NREQ];
        int         m_ptr, w, rr;
        logic [7:0] m_q, es, er;
        logic [3:0] eg;
        logic       m_err;
        logic [1:0] m_err_src;
        do_reset();
        pend = '0; m_ptr = 0; m_q = '0; m_err = 1'b0; m_err_src = '0;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    rr    = $urandom_range(0, 9);
                    pc[i] = (rr < 4) ? CMD_SET : (rr < 7) ? CMD_RST : (rr < 9) ? CMD_HOLD : CMD_ILL;
                    pa[i] = $urandom_range(0, NBITS - 1);
                    pend[i] = 1'b1;
                    set_req(i, pc[i], pa[i]);
                end
            end
            if (pend == 4'b0) begin
                w = $urandom_range(0, NREQ - 1);
                pc[w] = CMD_SET; pa[w] = $urandom_range(0, NBITS - 1);
                pend[w] = 1'b1;
                set_req(w, pc[w], pa[w]);
            end
            w  = pick(pend, m_ptr);
            eg = 4'b0001 << w;
            es = (pc[w] == CMD_SET) ? (8'h01 << pa[w]) : 8'h00;
            er = (pc[w] == CMD_RST) ? (8'h01 << pa[w]) : 8'h00;
            m_q = (m_q | es) & ~er;
            if (pc[w] == CMD_ILL && !m_err) begin m_err = 1'b1; m_err_src = 2'(w); end
            m_ptr = (w + 1) % NREQ;
            pend[w] = 1'b0;
            capture_txn();
            bif.req = pend;
            checks++; if (c_gnt !== eg) begin failures++; $display("FAIL rnd%0d_gnt got=%b exp=%b", t, c_gnt, eg); end
            checks++; if (c_s !== es || c_r !== er) begin failures++; $display("FAIL rnd%0d_pulse s=%h r=%h exp=%h/%h", t, c_s, c_r, es, er); end
            checks++; if (c_q !== m_q || c_qbar !== ~m_q) begin failures++; $display("FAIL rnd%0d_q q=%h qbar=%h exp=%h", t, c_q, c_qbar, m_q); end
            checks++; if (c_err !== m_err || c_err_src !== m_err_src) begin failures++; $display("FAIL rnd%0d_err err=%b src=%0d exp=%b/%0d", t, c_err, c_err_src, m_err, m_err_src); end
            $display("rnd txn %0d winner=%0d cmd=%b addr=%0d q=%h", t, w, pc[w], pa[w], c_q);
        end
    endtask

    initial begin
        bif.req  = '0;
        bif.cmd  = '0;
        bif.addr = '0;
        test_reset();
        test_single_set();
        test_all_set();
        test_illegal();
        test_same_addr();
        test_reset_in_apply();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_bank_arbiter.md
SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter NBITS, default 8, SHALL set the number of SR flag cells in the bank (power of 2, 2..16).
REQ-003 Parameter AW, default $clog2(NBITS), SHALL set the flag address width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req  in  NREQ  SHALL be per-requester request, held high until that requester's gnt bit is seen.
REQ-007 cmd  in  2*NREQ  SHALL be the per-requester command: 00 hold, 01 set, 10 reset, 11 illegal (S=R=1).
REQ-008 addr  in  AW*NREQ  SHALL be the per-requester target flag index.
REQ-009 gnt  out  NREQ  SHALL be a registered one-hot grant, high exactly one cycle per served request.
REQ-010 s_vec  out  NBITS  SHALL be the registered set pulses driven into the bank, at most one bit high.
REQ-011 r_vec  out  NBITS  SHALL be the registered reset pulses driven into the bank, at most one bit high.
REQ-012 q  out  NBITS  SHALL be the current flag values; qbar  out  NBITS  SHALL equal ~q.
REQ-013 err  out  1  SHALL be a sticky flag raised by an illegal command; err_src  out  $clog2(NREQ)  SHALL hold the index of the first offender.
REQ-014 busy  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, GRANT, APPLY; transitions IDLE->GRANT when |req, GRANT->APPLY unconditional, APPLY->IDLE unconditional.
REQ-016 In IDLE with |req, winner SHALL be the first asserted req at or after index ptr, searching upward mod NREQ; winner's cmd/addr SHALL be latched at that edge.
REQ-017 In GRANT, gnt[winner] SHALL be 1 and ptr SHALL update to (winner+1) mod NREQ at the GRANT->APPLY edge.
REQ-018 In APPLY, cmd 01 SHALL drive s_vec[addr]=1; cmd 10 SHALL drive r_vec[addr]=1; cmd 00 and 11 SHALL drive both vectors to 0.
REQ-019 q[addr] SHALL update at the APPLY->IDLE edge: set ->1, reset ->0; all other bits unchanged.
REQ-020 Command latency: req sampled at edge t, gnt high in cycle t..t+1, pulse in t+1..t+2, q valid after edge t+2; throughput one command per 3 cycles.
REQ-021 s_vec and r_vec SHALL never have a common bit high; s_vec and r_vec SHALL be 0 outside APPLY.
REQ-022 cmd 11 SHALL still be granted and rotate ptr; err SHALL be set at the GRANT->APPLY edge; err_src SHALL be written only when err was 0.
REQ-023 Same-address commands from different requesters SHALL apply in grant order; last applied wins.
REQ-024 req changes while busy SHALL be ignored until the next IDLE cycle; the served requester SHALL drop req in the cycle after gnt.
REQ-025 Out-of-range addr (≥NBITS, only possible if NBITS not 2^AW) SHALL be treated as cmd 00.

Reset
REQ-026 rst SHALL force state IDLE, ptr=0, gnt=0, s_vec=0, r_vec=0, q=0 (qbar all 1), err=0, err_src=0 at the next edge.
REQ-027 rst asserted in GRANT or APPLY SHALL abandon the latched command; no pulse SHALL follow and ptr SHALL return to 0.
REQ-028 rst SHALL dominate any simultaneous pulse into the bank.

Structure
REQ-029 Package sr_bank_pkg SHALL hold cmd encodings (CMD_HOLD, CMD_SET, CMD_RST, CMD_ILL) and the FSM state enum.
REQ-030 Sub-module sr_cell SHALL implement one clocked SR flag (clk, rst, s, r -> q, qbar; s=r=1 holds), instantiated NBITS times.
REQ-031 Arbitration, latch registers and FSM SHALL live in sr_bank_arbiter; no combinational path from req to gnt.

Verification
REQ-032 Reset then req=0001, cmd0=01, addr0=3 -> gnt=0001 one cycle, s_vec=0x08 one cycle, q=0x08 after 3 edges.
REQ-033 req=1111 all cmd=01, addr i=i, held per REQ-024 -> grants in order 0,1,2,3, q=0x0F after 12 cycles.
REQ-034 Req2 cmd=11 addr=5 -> gnt=0100, s_vec=r_vec=0, q unchanged, err=1, err_src=2; later req1 cmd=11 -> err_src stays 2.
REQ-035 q=0x08; req0 cmd=10 addr=3 and req1 cmd=01 addr=3 together -> req0 served first, then req1; final q[3]=1.
REQ-036 rst pulsed during APPLY of set addr=6 -> q=0x00, s_vec=0, busy=0, next grant goes to lowest asserted index.
